// File: rtl/custom_inputs_pkg.sv
// Shared constants for the custom_inputs Avalon-MM input peripheral.
package custom_inputs_pkg;

    localparam logic [1:0] REG_DATA         = 2'd0;
    localparam logic [1:0] REG_IRQ_MASK     = 2'd1;
    localparam logic [1:0] REG_EDGE_CAPTURE = 2'd2;
    localparam logic [1:0] REG_EDGE_SEL     = 2'd3;

    localparam int BUS_W = 32;

    // Wide enough to count to SYNC_STAGES+1 for SYNC_STAGES up to 4.
    localparam int PRIME_W = 3;

endpackage

// File: rtl/custom_inputs_sync.sv
// Purpose: per-bit synchronizer chain, previous-value register and edge detector.
// Latency: SYNC_STAGES cycles to sync, edge_event is combinational from sync/prev.
// Backpressure: none; free-running every cycle.
module custom_inputs_sync #(
    parameter int WIDTH       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] ins_new_signal,
    input  logic [WIDTH-1:0] edge_sel,
    input  logic             prime,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] edge_event
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;
    logic [WIDTH-1:0]                  prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage <= '0;
            prev  <= '0;
        end else begin
            stage <= {stage[SYNC_STAGES-2:0], ins_new_signal};
            prev  <= stage[SYNC_STAGES-1];
        end
    end

    assign sync = stage[SYNC_STAGES-1];

    // While priming, prev still follows sync so inputs high at reset never look like edges.
    assign edge_event = prime ? '0
                      : ((edge_sel & prev & ~sync) | (~edge_sel & ~prev & sync));

endmodule

// File: rtl/custom_inputs.sv
// Purpose: Avalon-MM input peripheral with W1C edge capture and maskable level irq.
// Latency: reads return one cycle after the strobe; irq one cycle after capture.
// Backpressure: none; one read per cycle accepted, no waitrequest.
module custom_inputs
    import custom_inputs_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       avs_s0_address,
    input  logic             avs_s0_read,
    output logic [31:0]      avs_s0_readdata,
    output logic             avs_s0_readdatavalid,
    input  logic             avs_s0_write,
    input  logic [31:0]      avs_s0_writedata,
    input  logic [WIDTH-1:0] ins_new_signal,
    output logic             irq
);

    localparam logic [PRIME_W-1:0] PRIME_END = PRIME_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]   sync;
    logic [WIDTH-1:0]   edge_event;
    logic [WIDTH-1:0]   irq_mask;
    logic [WIDTH-1:0]   edge_capture;
    logic [WIDTH-1:0]   edge_sel;
    logic [WIDTH-1:0]   clear;
    logic [PRIME_W-1:0] prime_cnt;
    logic               prime;
    logic [BUS_W-1:0]   rd_mux;
    logic               wdata_unused;

    assign wdata_unused = ^avs_s0_writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt <= '0;
        end else if (prime_cnt != PRIME_END) begin
            prime_cnt <= prime_cnt + PRIME_W'(1);
        end
    end

    assign prime = (prime_cnt != PRIME_END);

    custom_inputs_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk            (clk),
        .reset_n        (reset_n),
        .ins_new_signal (ins_new_signal),
        .edge_sel       (edge_sel),
        .prime          (prime),
        .sync           (sync),
        .edge_event     (edge_event)
    );

    always_comb begin
        clear = '0;
        if (avs_s0_write && (avs_s0_address == REG_EDGE_CAPTURE)) begin
            clear = avs_s0_writedata[WIDTH-1:0];
        end
    end

    // Set has priority over a same-cycle W1C clear so no edge is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_sel     <= '0;
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~clear) | edge_event;
            if (avs_s0_write && (avs_s0_address == REG_IRQ_MASK)) begin
                irq_mask <= avs_s0_writedata[WIDTH-1:0];
            end
            if (avs_s0_write && (avs_s0_address == REG_EDGE_SEL)) begin
                edge_sel <= avs_s0_writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_s0_address)
            REG_DATA:         rd_mux = BUS_W'(sync);
            REG_IRQ_MASK:     rd_mux = BUS_W'(irq_mask);
            REG_EDGE_CAPTURE: rd_mux = BUS_W'(edge_capture);
            REG_EDGE_SEL:     rd_mux = BUS_W'(edge_sel);
            default:          rd_mux = '0;
        endcase
    end

    // Register values sampled here are pre-write, so read-during-write returns old data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_s0_readdata      <= '0;
            avs_s0_readdatavalid <= 1'b0;
            irq                  <= 1'b0;
        end else begin
            avs_s0_readdatavalid <= avs_s0_read;
            if (avs_s0_read) begin
                avs_s0_readdata <= rd_mux;
            end
            irq <= |(edge_capture & irq_mask);
        end
    end

endmodule
